// File: rtl/posit_pkg.sv
// Shared constants and types for the 64-bit, es=4 posit encoder pipeline.
package posit_pkg;

  localparam int N      = 64;
  localparam int ES     = 4;
  localparam int FRAC_W = 57;
  localparam int K_W    = 7;
  localparam int BODY_W = N - 1;
  localparam int SH_W   = 6;
  localparam int STAGES = 3;

  localparam logic [N-1:0] MAXPOS = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [N-1:0] MINPOS = 64'h0000_0000_0000_0001;
  localparam logic [N-1:0] NAR    = 64'h8000_0000_0000_0000;

  // Regime values whose pattern no longer fits in the body.
  localparam logic signed [K_W-1:0] K_SAT_HI = 7'sd62;
  localparam logic signed [K_W-1:0] K_SAT_LO = -7'sd63;

  typedef enum logic [2:0] {
    SP_NONE,
    SP_ZERO,
    SP_NAR,
    SP_MAXPOS,
    SP_MINPOS
  } special_e;

endpackage

// File: rtl/right_shifter.sv
// Logical right shifter for the posit body; also reports the first shifted-out
// bit (guard) and the OR of all later shifted-out bits (sticky).
module right_shifter
  import posit_pkg::*;
#(
  parameter int DATA_W = BODY_W,
  parameter int AMT_W  = SH_W
) (
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] shifted,
  output logic              guard,
  output logic              sticky
);

  logic [2*DATA_W-1:0] wide;

  always_comb begin
    wide    = {data, {DATA_W{1'b0}}} >> amt;
    shifted = wide[2*DATA_W-1:DATA_W];
    guard   = wide[DATA_W-1];
    sticky  = |wide[DATA_W-2:0];
  end

endmodule

// File: rtl/posit_encoder_pipe.sv
// Three-stage posit<64,4> encoder: regime build, right shift, round/negate.
// Define POSIT_ENC_ROUND_EN for round-to-nearest-even; default build truncates.
module posit_encoder_pipe
  import posit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic signed [K_W-1:0] in_k,
  input  logic [ES-1:0]         in_expo,
  input  logic [FRAC_W-1:0]     in_frac,
  input  logic                  in_zero,
  input  logic                  in_nar,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_posit
);

`ifdef POSIT_ENC_ROUND_EN
  // Round-to-nearest-even; a carry out of the body clamps to maxpos.
  function automatic logic [BODY_W-1:0] round_rne(input logic [BODY_W-1:0] body,
                                                  input logic guard,
                                                  input logic sticky);
    logic [BODY_W:0] sum;
    sum = {1'b0, body} + {{BODY_W{1'b0}}, guard & (sticky | body[0])};
    return sum[BODY_W] ? MAXPOS[BODY_W-1:0] : sum[BODY_W-1:0];
  endfunction
`endif

  function automatic logic [N-1:0] apply_sign(input logic sign, input logic [N-1:0] mag);
    return sign ? -mag : mag;
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---- S1: regime build -------------------------------------------------
  // Seed is "10" (k>=0) or "01" (k<0) ahead of expo/frac; shifting it right
  // by k (ones fill) or -k-1 (zeros fill) yields the full regime run.
  special_e            sp_s1;
  logic                vld_p0;
  logic [BODY_W-1:0]   seed_p0;
  logic [SH_W-1:0]     amt_p0;
  logic                fill_p0;
  logic                sign_p0;
  special_e            sp_p0;

  always_comb begin
    sp_s1 = SP_NONE;
    if (in_nar)                sp_s1 = SP_NAR;
    else if (in_zero)          sp_s1 = SP_ZERO;
    else if (in_k >= K_SAT_HI) sp_s1 = SP_MAXPOS;
    else if (in_k <= K_SAT_LO) sp_s1 = SP_MINPOS;
  end

  always_ff @(posedge clk) begin
    if (rst)     vld_p0 <= 1'b0;
    else if (en) vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      seed_p0 <= {~in_k[K_W-1], in_k[K_W-1], in_expo, in_frac};
      amt_p0  <= in_k[K_W-1] ? ~in_k[SH_W-1:0] : in_k[SH_W-1:0];
      fill_p0 <= ~in_k[K_W-1];
      sign_p0 <= in_sign;
      sp_p0   <= sp_s1;
    end
  end

  // ---- S2: right shift --------------------------------------------------
  logic [BODY_W-1:0] shifted_s2;
  logic [BODY_W-1:0] fill_mask_s2;
  logic              guard_s2;
  logic              sticky_s2;
  logic              vld_p1;
  logic [BODY_W-1:0] body_p1;
  logic              guard_p1;
  logic              sticky_p1;
  logic              sign_p1;
  special_e          sp_p1;

  right_shifter #(.DATA_W(BODY_W), .AMT_W(SH_W)) u_shift (
    .data    (seed_p0),
    .amt     (amt_p0),
    .shifted (shifted_s2),
    .guard   (guard_s2),
    .sticky  (sticky_s2)
  );

  assign fill_mask_s2 = fill_p0 ? ~({BODY_W{1'b1}} >> amt_p0) : '0;

  always_ff @(posedge clk) begin
    if (rst)     vld_p1 <= 1'b0;
    else if (en) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      body_p1   <= shifted_s2 | fill_mask_s2;
      guard_p1  <= guard_s2;
      sticky_p1 <= sticky_s2;
      sign_p1   <= sign_p0;
      sp_p1     <= sp_p0;
    end
  end

  // ---- S3: round and negate ---------------------------------------------
  logic [BODY_W-1:0] rounded_s3;
  logic [N-1:0]      mag_s3;
  logic [N-1:0]      posit_s3;
  logic              vld_p2;
  logic [N-1:0]      posit_p2;

`ifdef POSIT_ENC_ROUND_EN
  assign rounded_s3 = round_rne(body_p1, guard_p1, sticky_p1);
`else
  logic unused_rnd;
  assign rounded_s3 = body_p1;
  assign unused_rnd = guard_p1 ^ sticky_p1;
`endif

  always_comb begin
    mag_s3 = {1'b0, rounded_s3};
    if (sp_p1 == SP_MAXPOS)      mag_s3 = MAXPOS;
    else if (sp_p1 == SP_MINPOS) mag_s3 = MINPOS;
    posit_s3 = apply_sign(sign_p1, mag_s3);
    if (sp_p1 == SP_ZERO)        posit_s3 = '0;
    else if (sp_p1 == SP_NAR)    posit_s3 = NAR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      posit_p2 <= '0;
    end else if (en) begin
      vld_p2   <= vld_p1;
      posit_p2 <= posit_s3;
    end
  end

  assign out_valid = vld_p2;
  assign out_posit = posit_p2;

endmodule

// File: tb/tb_posit_encoder_pipe.sv
// Bench for posit_encoder_pipe: directed corner cases, stall/reset scenarios,
// then random traffic scored against a bit-list reference model.
module tb_posit_encoder_pipe;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic signed [6:0] in_k;
  logic [3:0]        in_expo;
  logic [56:0]       in_frac;
  logic              in_zero;
  logic              in_nar;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_posit;

  int n_assert = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [63:0] sb[$];

  posit_encoder_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_k      (in_k),
    .in_expo   (in_expo),
    .in_frac   (in_frac),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference: write the posit body out bit by bit, keep 63, round from the rest.
  function automatic logic [63:0] ref_posit(input bit s, input int k, input logic [3:0] e,
                                            input logic [56:0] f, input bit z, input bit n);
    bit q[$];
    logic [62:0] body;
    logic [63:0] mag;
    bit g, st;
    if (n) return 64'h8000_0000_0000_0000;
    if (z) return 64'h0;
    if (k >= 62) mag = 64'h7FFF_FFFF_FFFF_FFFF;
    else if (k <= -63) mag = 64'h1;
    else begin
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = 3; i >= 0; i--) q.push_back(e[i]);
      for (int i = 56; i >= 0; i--) q.push_back(f[i]);
      body = '0;
      for (int i = 0; i < 63; i++) body = {body[61:0], q[i]};
      g  = (q.size() > 63) ? q[63] : 1'b0;
      st = 1'b0;
      for (int i = 64; i < q.size(); i++) st = st | q[i];
      mag = {1'b0, body};
`ifdef POSIT_ENC_ROUND_EN
      if (g && (st || body[0])) mag = mag + 64'd1;
      if (mag > 64'h7FFF_FFFF_FFFF_FFFF) mag = 64'h7FFF_FFFF_FFFF_FFFF;
`else
      if (g && st) mag = mag;
`endif
    end
    return s ? -mag : mag;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: sample handshakes on the falling edge, ahead of the rising edge that commits them.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("output_expected", {63'b0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) check("scoreboard", out_posit, sb.pop_front());
        n_out++;
      end
      if (in_valid && in_ready)
        sb.push_back(ref_posit(in_sign, int'(in_k), in_expo, in_frac, in_zero, in_nar));
    end
  end

  task automatic drive(input bit s, input int k, input logic [3:0] e, input logic [56:0] f,
                       input bit z, input bit n);
    logic [31:0] kk;
    kk       = k;
    in_sign  = s;
    in_k     = kk[6:0];
    in_expo  = e;
    in_frac  = f;
    in_zero  = z;
    in_nar   = n;
  endtask

  task automatic send_dir(input string tag, input bit s, input int k, input logic [3:0] e,
                          input logic [56:0] f, input bit z, input bit n, input logic [63:0] exp);
    drive(s, k, e, f, z, n);
    in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_lat2"}, {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
    check(tag, out_posit, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] exp_a;
    int out_before;
    int w;
    bit acc;
    logic [63:0] r64;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(0, 0, 4'h0, 57'h0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_out_posit", out_posit, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;

    send_dir("k0_pos",   0, 0,   4'h0, 57'h0, 0, 0, 64'h4000_0000_0000_0000);
    send_dir("k0_neg",   1, 0,   4'h0, 57'h0, 0, 0, 64'hC000_0000_0000_0000);
    send_dir("km1",      0, -1,  4'h0, 57'h0, 0, 0, 64'h2000_0000_0000_0000);
    send_dir("k61",      0, 61,  4'h0, 57'h0, 0, 0, 64'h7FFF_FFFF_FFFF_FFFE);
    send_dir("k62_max",  0, 62,  4'h5, 57'h1, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF);
    send_dir("k62_neg",  1, 62,  4'h0, 57'h0, 0, 0, 64'h8000_0000_0000_0001);
    send_dir("km63_min", 0, -63, 4'hF, 57'h3, 0, 0, 64'h0000_0000_0000_0001);
    send_dir("km64_min", 0, -64, 4'h0, 57'h0, 0, 0, 64'h0000_0000_0000_0001);
    send_dir("zero",     1, 5,   4'h3, 57'h7, 1, 0, 64'h0);
    send_dir("nar_zero", 0, 0,   4'h0, 57'h0, 1, 1, 64'h8000_0000_0000_0000);
    send_dir("nar_neg",  1, -70, 4'h9, 57'h1, 0, 1, 64'h8000_0000_0000_0000);
`ifdef POSIT_ENC_ROUND_EN
    send_dir("tie_even", 0, 1, 4'h0, 57'h1, 0, 0, 64'h6000_0000_0000_0000);
    send_dir("round_up", 0, 1, 4'h0, 57'h3, 0, 0, 64'h6000_0000_0000_0002);
`else
    send_dir("trunc_1",  0, 1, 4'h0, 57'h1, 0, 0, 64'h6000_0000_0000_0000);
    send_dir("trunc_3",  0, 1, 4'h0, 57'h3, 0, 0, 64'h6000_0000_0000_0001);
`endif

    // Back-to-back inputs into a stalled consumer.
    out_ready  = 1'b0;
    out_before = n_out;
    exp_a = ref_posit(0, 3, 4'hA, 57'h1_2345_6789_ABCD, 0, 0);
    drive(0, 3, 4'hA, 57'h1_2345_6789_ABCD, 0, 0); in_valid = 1'b1;
    @(posedge clk); #1;
    drive(1, -5, 4'h2, 57'h0_00FF_0000_1111, 0, 0);
    @(posedge clk); #1;
    drive(0, 20, 4'h7, 57'h1_FFFF_FFFF_FFFF, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid", {63'b0, out_valid}, 64'd1);
      check("stall_hold", out_posit, exp_a);
      check("stall_in_ready", {63'b0, in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("stall_delivered", 64'(n_out - out_before), 64'd3);
    check("stall_sb_empty", 64'(sb.size()), 64'd0);

    // Reset with two items in flight.
    out_before = n_out;
    drive(0, 2, 4'h1, 57'h5, 0, 0); in_valid = 1'b1;
    @(posedge clk); #1;
    drive(1, -2, 4'h4, 57'h9, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 7, 4'h6, 57'hAB, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_flight_valid", {63'b0, out_valid}, 64'd0);
    check("rst_flight_posit", out_posit, 64'd0);
    check("rst_flight_in_ready", {63'b0, in_ready}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_no_stale", {63'b0, out_valid}, 64'd0);
    end
    check("rst_nothing_out", 64'(n_out - out_before), 64'd0);
    @(posedge clk); #1;

    // Random traffic with random consumer back-pressure.
    for (int i = 0; i < 300; i++) begin
      r64 = {$urandom, $urandom};
      drive($urandom_range(0, 1), int'($signed(7'($urandom_range(0, 127)))),
            4'($urandom), r64[56:0],
            $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) in_k = 7'($urandom_range(0, 1) ? 62 - $urandom_range(0, 3) : -63 + $urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      acc = 1'b0;
      w   = 0;
      while (!acc && w < 100) begin
        @(negedge clk);
        acc = in_ready || !in_valid;
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
        w++;
      end
      check("rand_accept", {63'b0, acc}, 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/posit_encoder_pipe.md
POSIT_ENCODER_PIPE -- requirements
Module: posit_encoder_pipe

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: input fields valid.
REQ-004 SHALL have port in_ready, output, 1 bit: encoder accepts input this cycle.
REQ-005 SHALL have port in_sign, input, 1 bit: sign of value.
REQ-006 SHALL have port in_k, input, 7 bits, signed two's complement: regime value k.
REQ-007 SHALL have port in_expo, input, 4 bits: exponent field, es=4.
REQ-008 SHALL have port in_frac, input, 57 bits: fraction bits after hidden 1, MSB-aligned.
REQ-009 SHALL have port in_zero, input, 1 bit: encode zero, overrides all fields.
REQ-010 SHALL have port in_nar, input, 1 bit: encode NaR, overrides all fields including in_zero.
REQ-011 SHALL have port out_valid, output, 1 bit: out_posit valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts output.
REQ-013 SHALL have port out_posit, output, 64 bits: encoded posit word.

Function
REQ-014 SHALL transfer an input on in_valid && in_ready, and an output on out_valid && out_ready.
REQ-015 SHALL use 3 register stages: S1 regime build, S2 right shift, S3 round and negate; latency 3 cycles, throughput 1/cycle when unstalled.
REQ-016 SHALL advance all stages together on en = !out_valid || out_ready; in_ready = en; bubbles are not collapsed.
REQ-017 SHALL hold out_posit and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL encode the regime, for k>=0, as k+1 ones followed by one zero, and for k<0 as -k zeros followed by one one.
REQ-019 SHALL form the 63-bit body as regime, then in_expo, then in_frac, MSB-first, and discard bits beyond 63.
REQ-020 SHALL saturate k>=62 to maxpos 0x7FFF_FFFF_FFFF_FFFF and k<=-63 to minpos 0x0000_0000_0000_0001, before sign handling.
REQ-021 SHALL, when in_sign=1, output the 64-bit two's complement of {0, body}.
REQ-022 SHALL output 0x0 for in_zero, and 0x8000_0000_0000_0000 for in_nar, independent of sign and rounding.
REQ-023 SHALL never produce zero or NaR from a finite nonzero input; rounding clamps to minpos/maxpos magnitude.

Reset
REQ-024 SHALL clear all stage valid bits, out_valid=0, and out_posit=0 on rst; in-flight data is discarded.
REQ-025 SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-026 SHALL ignore in_valid during a cycle with rst asserted.

Configuration
REQ-027 SHALL, with macro POSIT_ENC_ROUND_EN defined, round round-to-nearest-even using guard bit (first discarded bit) and sticky (OR of remaining discarded bits).
REQ-028 SHALL, without POSIT_ENC_ROUND_EN, truncate discarded bits toward zero magnitude; latency stays 3.

Structure
REQ-029 SHALL take N=64, ES=4, FRAC_W=57, K_W=7, MAXPOS, MINPOS, NAR constants from shared package posit_pkg.
REQ-030 SHALL instantiate one sub-module right_shifter (63-bit data, 6-bit amount, sticky output) for stage S2.

Verification
REQ-031 k=0, expo=0, frac=0, sign=0 -> out_posit 0x4000_0000_0000_0000 three cycles later; sign=1 -> 0xC000_0000_0000_0000.
REQ-032 k=-1, expo=0, frac=0 -> 0x2000_0000_0000_0000; k=62 -> 0x7FFF_FFFF_FFFF_FFFF; k=-63 -> 0x0000_0000_0000_0001.
REQ-033 in_zero=1 -> 0x0; in_nar=1 with in_zero=1 -> 0x8000_0000_0000_0000.
REQ-034 with POSIT_ENC_ROUND_EN, k=1, expo=0, frac=57'h1 -> 0x6000_0000_0000_0000 (tie to even); frac=57'h3 -> 0x6000_0000_0000_0002; without the macro both -> 0x6000...0000 and 0x6000...0001.
REQ-035 three back-to-back inputs, out_ready held low 4 cycles -> first result held stable, in_ready low, all three delivered in order after release, none lost.
REQ-036 rst asserted with two items in flight -> out_valid=0 next cycle, no stale output after release.
